// File: rtl/sd_host_pkg.sv
// Shared definitions for the SD host transfer sequencer:
// FSM state encoding, error codes and the CMD12 index.
package sd_host_pkg;

    localparam logic [3:0] ST_IDLE         = 4'd0;
    localparam logic [3:0] ST_CMD_ISSUE    = 4'd1;
    localparam logic [3:0] ST_CMD_WAIT     = 4'd2;
    localparam logic [3:0] ST_DAT_WAIT_BUF = 4'd3;
    localparam logic [3:0] ST_DAT_XFER     = 4'd4;
    localparam logic [3:0] ST_GAP_STOP     = 4'd5;
    localparam logic [3:0] ST_ACMD_ISSUE   = 4'd6;
    localparam logic [3:0] ST_ACMD_WAIT    = 4'd7;
    localparam logic [3:0] ST_ERROR        = 4'd8;

    localparam logic [1:0] ERR_NONE        = 2'b00;
    localparam logic [1:0] ERR_CMD_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_CMD         = 2'b10;
    localparam logic [1:0] ERR_DATA        = 2'b11;

    localparam logic [5:0] CMD12_INDEX = 6'd12;

    typedef struct packed {
        logic has_data;
        logic multi;
        logic cnt_en;
        logic read;
    } xfer_mode_t;

    // States in which the data lines are owned by this transfer.
    function automatic logic is_dat_state(input logic [3:0] s);
        return (s == ST_DAT_WAIT_BUF) || (s == ST_DAT_XFER) ||
               (s == ST_GAP_STOP) || (s == ST_ACMD_ISSUE) ||
               (s == ST_ACMD_WAIT);
    endfunction

endpackage

// File: rtl/transfer_sequencer_timeout.sv
// Clearable saturating response-timeout counter used by the
// transfer sequencer; expired stays high once the count is all ones.
module seq_timeout_cnt #(
    parameter int TIMEOUT_W = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [TIMEOUT_W-1:0] cnt;

    assign expired = &cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/transfer_sequencer.sv
// SD transaction sequencer: command, response wait, block-by-block data.
// Optional TRANSFER_SEQ_AUTO_CMD12_EN adds an automatic CMD12 after multi-block.
import sd_host_pkg::*;

module transfer_sequencer #(
    parameter int BLK_CNT_W  = 16,
    parameter int BLK_SIZE_W = 12,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic [5:0]            cmd_index,
    input  logic                  cmd_has_data,
    input  logic                  tm_multi,
    input  logic                  tm_cnt_en,
    input  logic                  tm_read,
    input  logic [BLK_CNT_W-1:0]  block_count,
    input  logic [BLK_SIZE_W-1:0] block_size,
    input  logic                  stop_at_gap,
    input  logic                  continue_req,
    input  logic                  abort,
    input  logic                  error_clear,
    input  logic                  cmd_done,
    input  logic                  cmd_error,
    input  logic                  buf_ready,
    input  logic                  dat_block_done,
    input  logic                  dat_error,
    output logic                  cmd_start,
    output logic [5:0]            cmd_index_out,
    output logic                  dat_start,
    output logic                  dat_read,
    output logic [BLK_SIZE_W-1:0] dat_block_size,
    output logic                  cmd_inhibit,
    output logic                  dat_inhibit,
    output logic [BLK_CNT_W-1:0]  blocks_remaining,
    output logic                  cmd_complete_irq,
    output logic                  xfer_complete_irq,
    output logic                  block_gap_irq,
    output logic                  error_irq,
    output logic [1:0]            err_code
);

    localparam logic [BLK_CNT_W-1:0] ONE_BLK = 1;

    logic [3:0]            state_q, state_d;
    xfer_mode_t            mode_q, mode_d;
    logic [BLK_CNT_W-1:0]  count_d;
    logic [1:0]            err_d;
    logic [5:0]            idx_d;
    logic [BLK_SIZE_W-1:0] bsize_d;
    logic                  dphase_q, dphase_d;
    logic                  cs_d, ds_d, cc_d, xc_d, gap_d, eirq_d;
    logic                  blk_last;
    logic                  tmo_clear, tmo_en, tmo_expired;

    assign dat_read = mode_q.read;

    // Single-block transfers always end after one block.
    assign blk_last = !mode_q.multi ||
                      (mode_q.cnt_en && blocks_remaining <= ONE_BLK);

    assign tmo_clear = (state_q == ST_CMD_ISSUE) ||
                       (state_q == ST_ACMD_ISSUE);
    assign tmo_en    = (state_q == ST_CMD_WAIT) ||
                       (state_q == ST_ACMD_WAIT);

    seq_timeout_cnt #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_tmo (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (tmo_clear),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        count_d  = blocks_remaining;
        err_d    = err_code;
        idx_d    = cmd_index_out;
        bsize_d  = dat_block_size;
        dphase_d = dphase_q;
        cs_d     = 1'b0;
        ds_d     = 1'b0;
        cc_d     = 1'b0;
        xc_d     = 1'b0;
        gap_d    = 1'b0;
        eirq_d   = 1'b0;
        if (abort && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            err_d    = ERR_NONE;
            dphase_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d.has_data = cmd_has_data;
                        mode_d.multi    = tm_multi;
                        mode_d.cnt_en   = tm_cnt_en;
                        mode_d.read     = tm_read;
                        idx_d    = cmd_index;
                        bsize_d  = block_size;
                        count_d  = tm_multi ? block_count : ONE_BLK;
                        dphase_d = 1'b0;
                        state_d  = ST_CMD_ISSUE;
                    end
                end
                ST_CMD_ISSUE: begin
                    cs_d    = 1'b1;
                    state_d = ST_CMD_WAIT;
                end
                ST_CMD_WAIT: begin
                    if (cmd_error) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CMD;
                        eirq_d  = 1'b1;
                    end else if (cmd_done) begin
                        cc_d = 1'b1;
                        if (mode_q.has_data &&
                            (blocks_remaining != '0 ||
                             (!mode_q.cnt_en && mode_q.multi))) begin
                            state_d  = ST_DAT_WAIT_BUF;
                            dphase_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            xc_d    = mode_q.has_data;
                        end
                    end else if (tmo_expired) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CMD_TIMEOUT;
                        eirq_d  = 1'b1;
                    end
                end
                ST_DAT_WAIT_BUF: begin
                    if (buf_ready) begin
                        ds_d    = 1'b1;
                        state_d = ST_DAT_XFER;
                    end
                end
                ST_DAT_XFER: begin
                    if (dat_error) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_DATA;
                        eirq_d  = 1'b1;
                    end else if (dat_block_done) begin
                        if (mode_q.cnt_en && blocks_remaining != '0)
                            count_d = blocks_remaining - ONE_BLK;
                        if (blk_last) begin
`ifdef TRANSFER_SEQ_AUTO_CMD12_EN
                            if (mode_q.multi) begin
                                state_d = ST_ACMD_ISSUE;
                                idx_d   = CMD12_INDEX;
                            end else begin
                                state_d = ST_IDLE;
                                xc_d    = 1'b1;
                            end
`else
                            state_d = ST_IDLE;
                            xc_d    = 1'b1;
`endif
                        end else if (stop_at_gap) begin
                            state_d = ST_GAP_STOP;
                            gap_d   = 1'b1;
                        end else begin
                            state_d = ST_DAT_WAIT_BUF;
                        end
                    end
                end
                ST_GAP_STOP: begin
                    if (continue_req)
                        state_d = ST_DAT_WAIT_BUF;
                end
`ifdef TRANSFER_SEQ_AUTO_CMD12_EN
                ST_ACMD_ISSUE: begin
                    cs_d    = 1'b1;
                    state_d = ST_ACMD_WAIT;
                end
                ST_ACMD_WAIT: begin
                    if (cmd_error) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CMD;
                        eirq_d  = 1'b1;
                    end else if (cmd_done) begin
                        state_d = ST_IDLE;
                        xc_d    = 1'b1;
                    end else if (tmo_expired) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CMD_TIMEOUT;
                        eirq_d  = 1'b1;
                    end
                end
`endif
                ST_ERROR: begin
                    if (error_clear) begin
                        state_d  = ST_IDLE;
                        err_d    = ERR_NONE;
                        dphase_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q           <= ST_IDLE;
            mode_q            <= '0;
            blocks_remaining  <= '0;
            err_code          <= ERR_NONE;
            cmd_index_out     <= '0;
            dat_block_size    <= '0;
            dphase_q          <= 1'b0;
            cmd_start         <= 1'b0;
            dat_start         <= 1'b0;
            cmd_complete_irq  <= 1'b0;
            xfer_complete_irq <= 1'b0;
            block_gap_irq     <= 1'b0;
            error_irq         <= 1'b0;
            cmd_inhibit       <= 1'b0;
            dat_inhibit       <= 1'b0;
        end else begin
            state_q           <= state_d;
            mode_q            <= mode_d;
            blocks_remaining  <= count_d;
            err_code          <= err_d;
            cmd_index_out     <= idx_d;
            dat_block_size    <= bsize_d;
            dphase_q          <= dphase_d;
            cmd_start         <= cs_d;
            dat_start         <= ds_d;
            cmd_complete_irq  <= cc_d;
            xfer_complete_irq <= xc_d;
            block_gap_irq     <= gap_d;
            error_irq         <= eirq_d;
            cmd_inhibit       <= (state_d != ST_IDLE);
            dat_inhibit       <= is_dat_state(state_d) ||
                                 (state_d == ST_ERROR && dphase_d);
        end
    end

endmodule

// File: tb/tb_transfer_sequencer.sv
// Scoreboard bench for transfer_sequencer: directed transactions push
// expected output events; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_transfer_sequencer;

    localparam int BLK_CNT_W  = 16;
    localparam int BLK_SIZE_W = 12;
    localparam int TIMEOUT_W  = 16;

    localparam logic [2:0] EV_CS  = 3'd0;
    localparam logic [2:0] EV_CC  = 3'd1;
    localparam logic [2:0] EV_DS  = 3'd2;
    localparam logic [2:0] EV_GAP = 3'd3;
    localparam logic [2:0] EV_XC  = 3'd4;
    localparam logic [2:0] EV_ERR = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [5:0] cmd_index = '0;
    logic cmd_has_data = 1'b0;
    logic tm_multi = 1'b0;
    logic tm_cnt_en = 1'b0;
    logic tm_read = 1'b0;
    logic [BLK_CNT_W-1:0] block_count = '0;
    logic [BLK_SIZE_W-1:0] block_size = '0;
    logic stop_at_gap = 1'b0;
    logic continue_req = 1'b0;
    logic abort = 1'b0;
    logic error_clear = 1'b0;
    logic cmd_done = 1'b0;
    logic cmd_error = 1'b0;
    logic buf_ready = 1'b0;
    logic dat_block_done = 1'b0;
    logic dat_error = 1'b0;

    logic cmd_start;
    logic [5:0] cmd_index_out;
    logic dat_start;
    logic dat_read;
    logic [BLK_SIZE_W-1:0] dat_block_size;
    logic cmd_inhibit;
    logic dat_inhibit;
    logic [BLK_CNT_W-1:0] blocks_remaining;
    logic cmd_complete_irq;
    logic xfer_complete_irq;
    logic block_gap_irq;
    logic error_irq;
    logic [1:0] err_code;

    ev_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    transfer_sequencer #(
        .BLK_CNT_W  (BLK_CNT_W),
        .BLK_SIZE_W (BLK_SIZE_W),
        .TIMEOUT_W  (TIMEOUT_W)
    ) dut (
        .CLK               (clk),
        .RESET             (rst_n),
        .start             (start),
        .cmd_index         (cmd_index),
        .cmd_has_data      (cmd_has_data),
        .tm_multi          (tm_multi),
        .tm_cnt_en         (tm_cnt_en),
        .tm_read           (tm_read),
        .block_count       (block_count),
        .block_size        (block_size),
        .stop_at_gap       (stop_at_gap),
        .continue_req      (continue_req),
        .abort             (abort),
        .error_clear       (error_clear),
        .cmd_done          (cmd_done),
        .cmd_error         (cmd_error),
        .buf_ready         (buf_ready),
        .dat_block_done    (dat_block_done),
        .dat_error         (dat_error),
        .cmd_start         (cmd_start),
        .cmd_index_out     (cmd_index_out),
        .dat_start         (dat_start),
        .dat_read          (dat_read),
        .dat_block_size    (dat_block_size),
        .cmd_inhibit       (cmd_inhibit),
        .dat_inhibit       (dat_inhibit),
        .blocks_remaining  (blocks_remaining),
        .cmd_complete_irq  (cmd_complete_irq),
        .xfer_complete_irq (xfer_complete_irq),
        .block_gap_irq     (block_gap_irq),
        .error_irq         (error_irq),
        .err_code          (err_code)
    );

    function automatic string ev_name(input logic [2:0] k);
        case (k)
            EV_CS:   return "cmd_start";
            EV_CC:   return "cmd_complete_irq";
            EV_DS:   return "dat_start";
            EV_GAP:  return "block_gap_irq";
            EV_XC:   return "xfer_complete_irq";
            EV_ERR:  return "error_irq";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic sig_of(input logic [2:0] k);
        case (k)
            EV_CS:   return cmd_start;
            EV_CC:   return cmd_complete_irq;
            EV_DS:   return dat_start;
            EV_GAP:  return block_gap_irq;
            EV_XC:   return xfer_complete_irq;
            EV_ERR:  return error_irq;
            default: return 1'b0;
        endcase
    endfunction

    task automatic expect_ev(input logic [2:0] k, input int d);
        ev_t e;
        e.kind = k;
        e.data = 32'(d);
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [2:0] k, input logic [31:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s data %0d, required none",
                     ev_name(k), d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data != d) begin
                errors++;
                $display("FAIL event_order: got %s data %0d, required %s data %0d",
                         ev_name(k), d, ev_name(e.kind), e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_start)         observe(EV_CS,  32'(cmd_index_out));
            if (cmd_complete_irq)  observe(EV_CC,  32'(blocks_remaining));
            if (dat_start)         observe(EV_DS,  32'(blocks_remaining));
            if (block_gap_irq)     observe(EV_GAP, 32'(blocks_remaining));
            if (xfer_complete_irq) observe(EV_XC,  32'(blocks_remaining));
            if (error_irq)         observe(EV_ERR, 32'(err_code));
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_sig(input logic [2:0] k, input int max,
                            output int cyc);
        cyc = 0;
        while (!sig_of(k) && cyc < max) begin
            tick();
            cyc++;
        end
        if (!sig_of(k)) begin
            checks++;
            errors++;
            $display("FAIL wait_%s: got no pulse in %0d cycles, required pulse",
                     ev_name(k), max);
        end
    endtask

    task automatic issue(input logic [5:0] idx, input logic hd,
                         input logic multi, input logic cnt_en,
                         input logic rd, input int cnt);
        cmd_index    = idx;
        cmd_has_data = hd;
        tm_multi     = multi;
        tm_cnt_en    = cnt_en;
        tm_read      = rd;
        block_count  = BLK_CNT_W'(cnt);
        block_size   = 12'd512;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_cmd_done();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
    endtask

    task automatic pulse_blk_done();
        dat_block_done = 1'b1;
        tick();
        dat_block_done = 1'b0;
    endtask

    task automatic pulse_err_clear();
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
    endtask

    task automatic expect_multi_end();
`ifdef TRANSFER_SEQ_AUTO_CMD12_EN
        expect_ev(EV_CS, 12);
`endif
        expect_ev(EV_XC, 0);
    endtask

    task automatic close_multi();
        int c;
`ifdef TRANSFER_SEQ_AUTO_CMD12_EN
        wait_sig(EV_CS, 10, c);
        tick(3);
        pulse_cmd_done();
`endif
        wait_sig(EV_XC, 10, c);
    endtask

    task automatic multi_read(input int n);
        int c;
        expect_ev(EV_CS, 18);
        expect_ev(EV_CC, n);
        for (int b = n; b > 0; b--) expect_ev(EV_DS, b);
        expect_multi_end();
        issue(6'd18, 1'b1, 1'b1, 1'b1, 1'b1, n);
        wait_sig(EV_CS, 10, c);
        tick(2);
        pulse_cmd_done();
        for (int b = 0; b < n; b++) begin
            wait_sig(EV_DS, 10, c);
            if (b == 0) begin
                check("dat_read", 32'(dat_read), 1);
                check("dat_block_size", 32'(dat_block_size), 512);
            end
            tick(3);
            pulse_blk_done();
        end
        close_multi();
        tick(2);
        check("multi_read_cmd_inhibit", 32'(cmd_inhibit), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        tick(3);
        check("rst_cmd_start", 32'(cmd_start), 0);
        check("rst_cmd_index_out", 32'(cmd_index_out), 0);
        check("rst_blocks_remaining", 32'(blocks_remaining), 0);
        check("rst_dat_block_size", 32'(dat_block_size), 0);
        check("rst_cmd_inhibit", 32'(cmd_inhibit), 0);
        check("rst_err_code", 32'(err_code), 0);
        rst_n = 1'b1;
        tick(2);
        buf_ready = 1'b1;

        // Non-data CMD0
        expect_ev(EV_CS, 0);
        expect_ev(EV_CC, 1);
        issue(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("cmd0_inhibit_busy", 32'(cmd_inhibit), 1);
        wait_sig(EV_CS, 10, c);
        tick(4);
        pulse_cmd_done();
        tick(2);
        check("cmd0_inhibit_after", 32'(cmd_inhibit), 0);
        check("cmd0_dat_inhibit", 32'(dat_inhibit), 0);

        // 3-block read
        multi_read(3);

        // Response timeout
        expect_ev(EV_CS, 8);
        expect_ev(EV_ERR, 1);
        issue(6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        wait_sig(EV_CS, 10, c);
        wait_sig(EV_ERR, 70000, c);
        check("timeout_window", 32'(c >= 65535 && c <= 65537), 1);
        check("timeout_cmd_inhibit", 32'(cmd_inhibit), 1);
        check("timeout_dat_inhibit", 32'(dat_inhibit), 0);
        tick(2);
        check("timeout_err_held", 32'(err_code), 1);
        pulse_err_clear();
        check("clear_err_code", 32'(err_code), 0);
        check("clear_cmd_inhibit", 32'(cmd_inhibit), 0);

        // 4-block write, stop at gap after block 2
        expect_ev(EV_CS, 25);
        expect_ev(EV_CC, 4);
        expect_ev(EV_DS, 4);
        expect_ev(EV_DS, 3);
        expect_ev(EV_GAP, 2);
        expect_ev(EV_DS, 2);
        expect_ev(EV_DS, 1);
        expect_multi_end();
        issue(6'd25, 1'b1, 1'b1, 1'b1, 1'b0, 4);
        wait_sig(EV_CS, 10, c);
        tick(3);
        pulse_cmd_done();
        for (int b = 0; b < 4; b++) begin
            wait_sig(EV_DS, 10, c);
            if (b == 0) check("write_dat_read", 32'(dat_read), 0);
            tick(2);
            if (b == 1) stop_at_gap = 1'b1;
            pulse_blk_done();
            if (b == 1) begin
                stop_at_gap = 1'b0;
                tick(10);
                check("gap_blocks_remaining", 32'(blocks_remaining), 2);
                check("gap_dat_inhibit", 32'(dat_inhibit), 1);
                continue_req = 1'b1;
                tick();
                continue_req = 1'b0;
            end
        end
        close_multi();
        tick(2);

        // Abort with concurrent block done
        expect_ev(EV_CS, 18);
        expect_ev(EV_CC, 2);
        expect_ev(EV_DS, 2);
        issue(6'd18, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        wait_sig(EV_CS, 10, c);
        tick(2);
        pulse_cmd_done();
        wait_sig(EV_DS, 10, c);
        tick(2);
        abort = 1'b1;
        dat_block_done = 1'b1;
        tick();
        abort = 1'b0;
        dat_block_done = 1'b0;
        check("abort_cmd_inhibit", 32'(cmd_inhibit), 0);
        check("abort_dat_inhibit", 32'(dat_inhibit), 0);
        check("abort_count_kept", 32'(blocks_remaining), 2);
        tick(5);

        // cmd_done with cmd_error: error wins; restart ignored
        expect_ev(EV_CS, 17);
        expect_ev(EV_ERR, 2);
        issue(6'd17, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        wait_sig(EV_CS, 10, c);
        tick();
        issue(6'd55, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        tick();
        check("start_ignored_idx", 32'(cmd_index_out), 17);
        cmd_done = 1'b1;
        cmd_error = 1'b1;
        tick();
        cmd_done = 1'b0;
        cmd_error = 1'b0;
        wait_sig(EV_ERR, 5, c);
        check("cmderr_dat_inhibit", 32'(dat_inhibit), 0);
        pulse_err_clear();
        check("cmderr_cleared", 32'(err_code), 0);

        // Single-block write with data error
        expect_ev(EV_CS, 24);
        expect_ev(EV_CC, 1);
        expect_ev(EV_DS, 1);
        expect_ev(EV_ERR, 3);
        issue(6'd24, 1'b1, 1'b0, 1'b1, 1'b0, 7);
        wait_sig(EV_CS, 10, c);
        tick(2);
        pulse_cmd_done();
        wait_sig(EV_DS, 10, c);
        tick(2);
        dat_error = 1'b1;
        tick();
        dat_error = 1'b0;
        wait_sig(EV_ERR, 5, c);
        check("daterr_dat_inhibit", 32'(dat_inhibit), 1);
        check("daterr_code", 32'(err_code), 3);
        pulse_err_clear();
        check("daterr_clear_inhibit", 32'(dat_inhibit), 0);

        // 2-block read (auto CMD12 when enabled)
        multi_read(2);
`ifdef TRANSFER_SEQ_AUTO_CMD12_EN
        check("end_cmd_index_out", 32'(cmd_index_out), 12);
`else
        check("end_cmd_index_out", 32'(cmd_index_out), 18);
`endif

        tick(5);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/transfer_sequencer.md
# transfer_sequencer

Sequences one SD transaction: issues the command through the CMD block, waits for its response, then drives the DAT block block-by-block until the programmed count is exhausted. Sits between the host register file (Command, Transfer Mode, Block Count/Size, Block Gap Control) and the CMD, DAT and buffer blocks inside `sd_host`. Produces Present State inhibit bits and interrupt-status pulses.

## Interface
- `BLK_CNT_W`, 16, block count width
- `BLK_SIZE_W`, 12, block size width (bytes)
- `TIMEOUT_W`, 16, response-timeout counter width; timeout = 2^TIMEOUT_W−1 cycles
- `CLK`  in  1  sole clock
- `RESET`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse: Command Register written
- `cmd_index`  in  6  command index
- `cmd_has_data`  in  1  data-present select
- `tm_multi`, `tm_cnt_en`, `tm_read`  in  1 each  Transfer Mode bits
- `block_count`  in  BLK_CNT_W; `block_size`  in  BLK_SIZE_W
- `stop_at_gap`, `continue_req`, `abort`, `error_clear`  in  1 each
- `cmd_done`, `cmd_error`  in  1 each  CMD block response pulses
- `buf_ready`  in  1  buffer holds a full block (write) / space for one (read)
- `dat_block_done`, `dat_error`  in  1 each  DAT block pulses
- `cmd_start`  out  1; `cmd_index_out`  out  6
- `dat_start`  out  1; `dat_read`  out  1; `dat_block_size`  out  BLK_SIZE_W
- `cmd_inhibit`, `dat_inhibit`  out  1 each
- `blocks_remaining`  out  BLK_CNT_W
- `cmd_complete_irq`, `xfer_complete_irq`, `block_gap_irq`, `error_irq`  out  1 each (pulses)
- `err_code`  out  2  00 none, 01 cmd timeout, 10 cmd error, 11 data error

## Operation
- States: IDLE, CMD_ISSUE, CMD_WAIT, DAT_WAIT_BUF, DAT_XFER, GAP_STOP, ACMD_ISSUE, ACMD_WAIT, ERROR.
- IDLE: `start` latches index, mode, size; count loaded = `tm_multi ? block_count : 1`. → CMD_ISSUE. `start` outside IDLE ignored.
- CMD_ISSUE: `cmd_start`=1 one cycle → CMD_WAIT; timeout counter cleared.
- CMD_WAIT: `cmd_error` → ERROR (10); counter saturating → ERROR (01); `cmd_done` → pulse `cmd_complete_irq`; then if `cmd_has_data` and count≠0 (or `tm_cnt_en`=0 with `tm_multi`) → DAT_WAIT_BUF, else → IDLE with `xfer_complete_irq` only if `cmd_has_data`.
- DAT_WAIT_BUF: `buf_ready` → `dat_start` pulse, → DAT_XFER.
- DAT_XFER: `dat_error` → ERROR (11). `dat_block_done`: decrement count if `tm_cnt_en`; if count hits 0 → end-of-transfer; else if `stop_at_gap` → GAP_STOP, pulse `block_gap_irq`; else → DAT_WAIT_BUF.
- End-of-transfer: → IDLE, pulse `xfer_complete_irq`.
- GAP_STOP: `continue_req` → DAT_WAIT_BUF.
- ERROR: `error_irq` pulses on entry; `err_code` held; `error_clear` → IDLE, `err_code`=00.
- `abort` (any non-IDLE state, highest priority): → IDLE next cycle, no interrupt.
- `cmd_inhibit`=1 in every state except IDLE; `dat_inhibit`=1 from DAT_WAIT_BUF through GAP_STOP/ACMD_* and in ERROR when data phase was entered.
- `blocks_remaining` = live counter; count arithmetic unsigned, never wraps below 0.

## Timing
- Reset: state IDLE, all outputs 0, `cmd_index_out`=0, `blocks_remaining`=0, `dat_block_size`=0.
- `start`@n → `cmd_start`=1 @n+2 (IDLE→CMD_ISSUE registered, pulse registered).
- `cmd_done`@n → `cmd_complete_irq`@n+1; `dat_start` earliest @n+2 if `buf_ready`.
- `dat_block_done` and `abort` same cycle: abort wins, count not decremented.
- Simultaneous `cmd_done`+`cmd_error`: error wins. `cmd_done` on timeout-saturation cycle: done wins.
- All pulses exactly one cycle; all outputs registered.

## Configuration
- `TRANSFER_SEQ_AUTO_CMD12_EN` defined: end-of-transfer of a multi-block transfer goes ACMD_ISSUE (`cmd_index_out`=12, `cmd_start` pulse) → ACMD_WAIT (same error/timeout rules) → IDLE with `xfer_complete_irq` after its `cmd_done`. Undefined: ACMD states absent, end-of-transfer → IDLE directly.

## Structure
- Shared package `sd_host_pkg`: state encoding, `err_code` values, CMD12 index constant.
- One sub-module `seq_timeout_cnt`: clearable saturating counter, TIMEOUT_W wide, `expired` flag.

## Test plan
- Non-data CMD0: `start`, `cmd_done` 5 cycles later → `cmd_complete_irq` once, no `dat_start`, `cmd_inhibit` low after.
- 3-block read, `tm_cnt_en`=1, `buf_ready`=1 → three `dat_start`, `blocks_remaining` 3→2→1→0, one `xfer_complete_irq`.
- No `cmd_done` for 65535 cycles → `error_irq`, `err_code`=01; `error_clear` → IDLE, code 00.
- 4-block write with `stop_at_gap`=1 after block 2 → `block_gap_irq`, holds with `blocks_remaining`=2 until `continue_req`.
- `abort` during DAT_XFER with concurrent `dat_block_done` → IDLE next cycle, count unchanged, no irq.
- With AUTO_CMD12 macro, 2-block read → after last block `cmd_index_out`=12, `cmd_start`, then `xfer_complete_irq`.
